alu_issue_stage: RTL and testbench



---
 rtl/alu_issue_stage_pkg.sv | 61 ++++++
 rtl/alu_issue_stage_decode.sv | 24 ++
 rtl/alu_issue_stage.sv | 130 +++++++++++++
 tb/tb_alu_issue_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU issue definitions: opcode mnemonics, instruction field positions,
// the buffered issue entry, and the shift-operand mask helper.
package alu_issue_stage_pkg;

    localparam int kDw  = 8;
    localparam int kRiw = 3;
    localparam int kIw  = 9;

    // Instruction layout: opcode [8:6], rs [5:3], rt [2:0]; rd is rs.
    localparam int kOpMsb = 8;
    localparam int kOpLsb = 6;
    localparam int kRsMsb = 5;
    localparam int kRsLsb = 3;
    localparam int kRtMsb = 2;
    localparam int kRtLsb = 0;

    localparam int kShamtW = 3;

    localparam logic [2:0] kOpAdd = 3'd0;
    localparam logic [2:0] kOpOr  = 3'd1;
    localparam logic [2:0] kOpXor = 3'd2;
    localparam logic [2:0] kOpAnd = 3'd3;
    localparam logic [2:0] kOpLt  = 3'd4;
    localparam logic [2:0] kOpEq  = 3'd5;
    localparam logic [2:0] kOpSll = 3'd6;
    localparam logic [2:0] kOpSrl = 3'd7;

    typedef enum logic [2:0] {
        OP_ADD = kOpAdd,
        OP_OR  = kOpOr,
        OP_XOR = kOpXor,
        OP_AND = kOpAnd,
        OP_LT  = kOpLt,
        OP_EQ  = kOpEq,
        OP_SLL = kOpSll,
        OP_SRL = kOpSrl
    } op_mne;

    typedef struct packed {
        op_mne            op;
        logic [kDw-1:0]   a;
        logic [kDw-1:0]   b;
        logic [kRiw-1:0]  rd;
        logic [kRiw-1:0]  rs;
        logic [kRiw-1:0]  rt;
        logic             pend_a;
        logic             pend_b;
    } issue_entry_t;

    // Shifts only consume the low shift-amount bits of operand B.
    function automatic logic [kDw-1:0] shiftMask(input op_mne op, input logic [kDw-1:0] v);
        logic [kDw-1:0] r;
        r = v;
        if (op == OP_SLL || op == OP_SRL) begin
            r = '0;
            r[kShamtW-1:0] = v[kShamtW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational decode of one instruction word plus its register-file values
// into an issue entry; pending flags are always clear at this point.
module issue_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [kIw-1:0]  instr,
    input  logic [kDw-1:0]  rsVal,
    input  logic [kDw-1:0]  rtVal,
    output issue_entry_t    entry
);

    always_comb begin
        entry        = '0;
        entry.op     = op_mne'(instr[kOpMsb:kOpLsb]);
        entry.rs     = instr[kRsMsb:kRsLsb];
        entry.rd     = instr[kRsMsb:kRsLsb];
        entry.rt     = instr[kRtMsb:kRtLsb];
        entry.a      = rsVal;
        entry.b      = shiftMask(op_mne'(instr[kOpMsb:kOpLsb]), rtVal);
        entry.pend_a = 1'b0;
        entry.pend_b = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, 2-entry skid buffer and result forwarding.
// Optional ISSUE_STATS_EN adds saturating issued/stall counters.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DW  = kDw,
    parameter int RIW = kRiw,
    parameter int IW  = kIw
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IW-1:0]  in_instr,
    input  logic [DW-1:0]  in_rs_val,
    input  logic [DW-1:0]  in_rt_val,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2:0]     out_op,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [RIW-1:0] out_rd,
    input  logic [DW-1:0]  alu_result
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]    issued_cnt,
    output logic [15:0]    stall_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. Valid never depends on ready; once out_valid is up, out_* hold
    // until the ALU side takes them. in_ready is purely a register (!skidValid).

    issue_entry_t mainQ, mainD;
    issue_entry_t skidQ, skidD;
    issue_entry_t decEntry;
    logic         mainValid, mainValidD;
    logic         skidValid, skidValidD;
    logic         accept;
    logic         handoff;

    issue_decode u_decode (
        .instr (in_instr),
        .rsVal (in_rs_val),
        .rtVal (in_rt_val),
        .entry (decEntry)
    );

    assign in_ready  = !skidValid;
    assign accept    = in_valid & in_ready;
    assign handoff   = mainValid & out_ready;

    assign out_valid = mainValid;
    assign out_op    = mainQ.op;
    assign out_a     = mainQ.a;
    assign out_b     = mainQ.b;
    assign out_rd    = mainQ.rd;

    always_comb begin
        mainD      = mainQ;
        skidD      = skidQ;
        mainValidD = mainValid;
        skidValidD = skidValid;

        if (!mainValid) begin
            if (accept) begin
                mainD      = decEntry;
                mainValidD = 1'b1;
            end
        end else if (handoff) begin
            if (skidValid) begin
                // Pending operands were captured while main was stalled; the
                // departing main result is exactly what they were waiting for.
                mainD = skidQ;
                if (skidQ.pend_a) mainD.a = alu_result;
                if (skidQ.pend_b) mainD.b = shiftMask(skidQ.op, alu_result);
                mainD.pend_a = 1'b0;
                mainD.pend_b = 1'b0;
                skidValidD   = 1'b0;
            end else if (accept) begin
                // Register file write lands on this same edge, so bypass it.
                mainD = decEntry;
                if (decEntry.rs == mainQ.rd) mainD.a = alu_result;
                if (decEntry.rt == mainQ.rd) mainD.b = shiftMask(decEntry.op, alu_result);
            end else begin
                mainValidD = 1'b0;
            end
        end else if (!skidValid && accept) begin
            skidD        = decEntry;
            skidD.pend_a = (decEntry.rs == mainQ.rd);
            skidD.pend_b = (decEntry.rt == mainQ.rd);
            skidValidD   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ     <= '0;
            skidQ     <= '0;
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else begin
            mainQ     <= mainD;
            skidQ     <= skidD;
            mainValid <= mainValidD;
            skidValid <= skidValidD;
        end
    end

    // Main never carries pending flags, and its destination is its rs.
    always @(posedge clk) begin
        if (rst_n && mainValid) begin
            assert (!mainQ.pend_a && !mainQ.pend_b && (mainQ.rd == mainQ.rs));
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (handoff && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, issue, backpressure, forwarding,
// shift masking and (with ISSUE_STATS_EN) the statistics counters.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_instr = '0;
    logic [7:0] in_rs_val = '0;
    logic [7:0] in_rt_val = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_op;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [2:0] out_rd;
    logic [7:0] alu_result;
`ifdef ISSUE_STATS_EN
    logic [15:0] issued_cnt;
    logic [15:0] stall_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Reference ALU driving alu_result from whatever the stage presents.
    function automatic logic [7:0] aluModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a & b;
            3'd4:    return {7'd0, a < b};
            3'd5:    return {7'd0, a == b};
            3'd6:    return a << b[2:0];
            default: return a >> b[2:0];
        endcase
    endfunction

    assign alu_result = aluModel(out_op, out_a, out_b);

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs_val  (in_rs_val),
        .in_rt_val  (in_rt_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .alu_result (alu_result)
`ifdef ISSUE_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [7:0] rsVal, input logic [7:0] rtVal);
        in_valid  = 1'b1;
        in_instr  = {op, rs, rt};
        in_rs_val = rsVal;
        in_rt_val = rtVal;
    endtask

    task automatic checkOut(input string tag, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] rd);
        check({tag, "_valid"}, 16'(out_valid), 16'd1);
        check({tag, "_op"}, 16'(out_op), 16'(op));
        check({tag, "_a"}, 16'(out_a), 16'(a));
        check({tag, "_b"}, 16'(out_b), 16'(b));
        check({tag, "_rd"}, 16'(out_rd), 16'(rd));
    endtask

    initial begin
        // Power-on reset
        step();
        step();
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_out_op", 16'(out_op), 16'(kOpAdd));
        check("rst_out_a", 16'(out_a), 16'd0);
        check("rst_out_b", 16'(out_b), 16'd0);
        check("rst_out_rd", 16'(out_rd), 16'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 16'(out_valid), 16'd0);

        // Zero-stall issue: ADD r1,r2 with 3,4
        out_ready = 1'b1;
        push(kOpAdd, 3'd1, 3'd2, 8'd3, 8'd4);
        step();
        in_valid = 1'b0;
        checkOut("add", kOpAdd, 8'd3, 8'd4, 3'd1);
        step();
        check("add_drained", 16'(out_valid), 16'd0);

        // SLL operand B keeps only its low three bits
        push(kOpSll, 3'd2, 3'd3, 8'h07, 8'hFD);
        step();
        in_valid = 1'b0;
        checkOut("sll", kOpSll, 8'h07, 8'h05, 3'd2);
        step();
        check("sll_drained", 16'(out_valid), 16'd0);

        // Backpressure: three back-to-back, only two fit
        out_ready = 1'b0;
        push(kOpOr, 3'd4, 3'd5, 8'h10, 8'h01);
        step();
        check("bp1_in_ready", 16'(in_ready), 16'd1);
        check("bp1_a", 16'(out_a), 16'h10);
        push(kOpAnd, 3'd5, 3'd6, 8'hF0, 8'h3C);
        step();
        check("bp2_in_ready", 16'(in_ready), 16'd0);
        check("bp2_hold_op", 16'(out_op), 16'(kOpOr));
        push(kOpEq, 3'd6, 3'd7, 8'h22, 8'h22);
        step();
        check("bp3_in_ready", 16'(in_ready), 16'd0);
        checkOut("bp3_hold", kOpOr, 8'h10, 8'h01, 3'd4);
        out_ready = 1'b1;
        step();
        checkOut("bp_i2", kOpAnd, 8'hF0, 8'h3C, 3'd5);
        check("bp_i2_in_ready", 16'(in_ready), 16'd1);
        step();
        in_valid = 1'b0;
        checkOut("bp_i3", kOpEq, 8'h22, 8'h22, 3'd6);
        step();
        check("bp_drained", 16'(out_valid), 16'd0);
`ifdef ISSUE_STATS_EN
        check("stats_issued", issued_cnt, 16'd5);
        check("stats_stall", stall_cnt, 16'd2);
`endif

        // In-buffer hazard: XOR r1,r1 waits on stalled ADD r1 (3+6=9)
        out_ready = 1'b0;
        push(kOpAdd, 3'd1, 3'd2, 8'd3, 8'd6);
        step();
        push(kOpXor, 3'd1, 3'd1, 8'd0, 8'd0);
        step();
        in_valid = 1'b0;
        check("raw_skid_in_ready", 16'(in_ready), 16'd0);
        check("raw_hold_a", 16'(out_a), 16'd3);
        out_ready = 1'b1;
        step();
        checkOut("raw_xor", kOpXor, 8'd9, 8'd9, 3'd1);
        step();
        check("raw_drained", 16'(out_valid), 16'd0);

        // Same-edge hazard: ADD r2 (2+3=5) leaves as OR r3,r2 arrives
        push(kOpAdd, 3'd2, 3'd0, 8'd2, 8'd3);
        step();
        push(kOpOr, 3'd3, 3'd2, 8'h40, 8'h00);
        step();
        in_valid = 1'b0;
        checkOut("fwd_or", kOpOr, 8'h40, 8'h05, 3'd3);
        step();
        check("fwd_drained", 16'(out_valid), 16'd0);

        // Forwarded shift amount is masked too: 0x10+0x0B=0x1B -> 3
        out_ready = 1'b0;
        push(kOpAdd, 3'd1, 3'd2, 8'h10, 8'h0B);
        step();
        push(kOpSll, 3'd2, 3'd1, 8'h81, 8'hEE);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checkOut("fwd_sll", kOpSll, 8'h81, 8'h03, 3'd2);
        step();
        check("fwd_sll_drained", 16'(out_valid), 16'd0);

        // Reset with both entries full drops everything
        out_ready = 1'b0;
        push(kOpOr, 3'd1, 3'd2, 8'd1, 8'd2);
        step();
        push(kOpAnd, 3'd3, 3'd4, 8'd3, 8'd4);
        step();
        in_valid = 1'b0;
        check("full_in_ready", 16'(in_ready), 16'd0);
        rst_n = 1'b0;
        step();
        check("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check("mid_rst_in_ready", 16'(in_ready), 16'd1);
        check("mid_rst_op", 16'(out_op), 16'(kOpAdd));
        check("mid_rst_a", 16'(out_a), 16'd0);
        check("mid_rst_b", 16'(out_b), 16'd0);
`ifdef ISSUE_STATS_EN
        check("mid_rst_issued", issued_cnt, 16'd0);
        check("mid_rst_stall", stall_cnt, 16'd0);
`endif
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("no_replay_1", 16'(out_valid), 16'd0);
        step();
        check("no_replay_2", 16'(out_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
